vec_elem_sequencer: RTL and testbench

//   Initiator side of the vector register file (VRF) element-streaming interface.

---
 rtl/vec_elem_sequencer.sv | 248 ++++++++++++++++++++++++
 tb/tb_vec_elem_sequencer.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vec_elem_sequencer.sv
// vec_elem_sequencer: initiator side of the VRF element-streaming interface.
// Accepts one vector instruction, holds the VRF request while elements stream,
// computes the result element combinationally, and reports completion.
// Optional feature macro: VEC_SEQ_MACC_EN (op 8 = A*B+C; illegal when undefined).

package vec_elem_sequencer_pkg;
    typedef enum logic [2:0] {
        LMUL_1    = 3'b000,
        LMUL_2    = 3'b001,
        LMUL_4    = 3'b010,
        LMUL_8    = 3'b011,
        LMUL_RSVD = 3'b100,
        LMUL_F8   = 3'b101,
        LMUL_F4   = 3'b110,
        LMUL_F2   = 3'b111
    } vlmul_e;
endpackage

module vec_elem_sequencer
    import vec_elem_sequencer_pkg::*;
#(
    parameter int unsigned VLEN          = 128,
    parameter int unsigned ELEN          = 32,
    parameter int unsigned AddrWidth     = 5,
    parameter int unsigned TimeoutCycles = 1024
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 instr_valid_i,
    output logic                 instr_ready_o,
    input  logic [3:0]           op_i,
    input  logic [AddrWidth-1:0] vs1_i,
    input  logic [AddrWidth-1:0] vs2_i,
    input  logic [AddrWidth-1:0] vd_i,
    input  logic [ELEN-1:0]      scalar_i,
    input  logic                 use_scalar_i,
    input  logic [1:0]           num_operands_i,
    input  logic                 wb_en_i,
    input  vlmul_e               lmul_i,
    output logic                 busy_o,
    output logic                 done_valid_o,
    output logic                 done_error_o,
    output logic [15:0]          elem_cnt_o,
    output logic                 vrf_req_o,
    output logic                 vrf_we_o,
    output logic [AddrWidth-1:0] vrf_raddr_a_o,
    output logic [AddrWidth-1:0] vrf_raddr_b_o,
    output logic [AddrWidth-1:0] vrf_waddr_o,
    output logic [1:0]           vrf_num_operands_o,
    output vlmul_e               vrf_lmul_o,
    input  logic [ELEN-1:0]      vrf_rdata_a_i,
    input  logic [ELEN-1:0]      vrf_rdata_b_i,
    input  logic [ELEN-1:0]      vrf_rdata_c_i,
    output logic [ELEN-1:0]      vrf_wdata_o,
    input  logic                 vrf_done_i
);

    localparam int unsigned COUNT  = VLEN / ELEN;
    localparam int unsigned PhaseW = $clog2(COUNT + 8);
    localparam int unsigned TimerW = $clog2(TimeoutCycles + 1);
    localparam int unsigned ShW    = $clog2(ELEN);

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_MIN  = 4'd5,
        OP_MAX  = 4'd6,
        OP_SLL  = 4'd7,
        OP_MACC = 4'd8
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_e;

    state_e                state_q, state_d;
    logic [3:0]            op_q;
    logic [AddrWidth-1:0]  vs1_q, vs2_q, vd_q;
    logic [ELEN-1:0]       scalar_q;
    logic                  use_scalar_q;
    logic [1:0]            num_ops_q;
    logic                  wb_en_q;
    vlmul_e                lmul_q;
    logic                  err_q;
    logic [15:0]           elem_cnt_q;
    logic [PhaseW-1:0]     phase_q;
    logic [3:0]            pass_q;
    logic [TimerW-1:0]     timer_q;

    logic                  accept, op_legal, run, timeout;
    logic [PhaseW-1:0]     elem_total, ops_ext, first_elem, last_elem, last_phase;
    logic [3:0]            num_passes;
    logic                  pass_active, elem_cycle;
    logic [ELEN-1:0]       opa, opb, result;

    assign run     = (state_q == ST_RUN);
    assign accept  = (state_q == ST_IDLE) && instr_valid_i;
    assign timeout = (timer_q == TimerW'(TimeoutCycles - 1));

`ifdef VEC_SEQ_MACC_EN
    assign op_legal = (op_i <= OP_MACC);
`else
    assign op_legal = (op_i < OP_MACC);
    logic unused_rdata_c;
    assign unused_rdata_c = ^vrf_rdata_c_i;
`endif

    // FSM state register
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // FSM next-state and handshake/request outputs
    always_comb begin
        state_d       = state_q;
        instr_ready_o = 1'b0;
        busy_o        = 1'b0;
        done_valid_o  = 1'b0;
        done_error_o  = 1'b0;
        vrf_req_o     = 1'b0;
        vrf_we_o      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                instr_ready_o = 1'b1;
                if (instr_valid_i) state_d = op_legal ? ST_RUN : ST_DONE;
            end
            ST_RUN: begin
                busy_o    = 1'b1;
                vrf_req_o = 1'b1;
                vrf_we_o  = wb_en_q;
                if (vrf_done_i || timeout) state_d = ST_DONE;
            end
            ST_DONE: begin
                busy_o       = 1'b1;
                done_valid_o = 1'b1;
                done_error_o = err_q;
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Per-pass element window and number of register passes for the latched grouping
    always_comb begin
        elem_total = PhaseW'(COUNT);
        num_passes = 4'd1;
        case (lmul_q)
            LMUL_F8: elem_total = PhaseW'(COUNT >> 3);
            LMUL_F4: elem_total = PhaseW'(COUNT >> 2);
            LMUL_F2: elem_total = PhaseW'(COUNT >> 1);
            LMUL_2:  num_passes = 4'd2;
            LMUL_4:  num_passes = 4'd4;
            LMUL_8:  num_passes = 4'd8;
            default: begin
                elem_total = PhaseW'(COUNT);
                num_passes = 4'd1;
            end
        endcase
        ops_ext     = PhaseW'(num_ops_q);
        first_elem  = ops_ext + PhaseW'(1);
        last_elem   = ops_ext + elem_total;
        last_phase  = ops_ext + elem_total + PhaseW'(1);
        pass_active = (pass_q < num_passes);
        // With zero elements per pass last_elem < first_elem, so no element cycles occur.
        elem_cycle  = run && pass_active && (phase_q >= first_elem) && (phase_q <= last_elem);
    end

    // Instruction latches, phase/pass tracking, timeout timer, element counter, error flag
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            op_q         <= '0;
            vs1_q        <= '0;
            vs2_q        <= '0;
            vd_q         <= '0;
            scalar_q     <= '0;
            use_scalar_q <= 1'b0;
            num_ops_q    <= '0;
            wb_en_q      <= 1'b0;
            lmul_q       <= LMUL_1;
            err_q        <= 1'b0;
            elem_cnt_q   <= '0;
            phase_q      <= '0;
            pass_q       <= '0;
            timer_q      <= '0;
        end else if (accept) begin
            op_q         <= op_i;
            vs1_q        <= vs1_i;
            vs2_q        <= vs2_i;
            vd_q         <= vd_i;
            scalar_q     <= scalar_i;
            use_scalar_q <= use_scalar_i;
            num_ops_q    <= num_operands_i;
            wb_en_q      <= wb_en_i;
            lmul_q       <= lmul_i;
            err_q        <= !op_legal;
            elem_cnt_q   <= '0;
            phase_q      <= '0;
            pass_q       <= '0;
            timer_q      <= '0;
        end else if (run) begin
            timer_q <= timer_q + TimerW'(1);
            if (phase_q == last_phase) begin
                phase_q <= '0;
                if (pass_active) pass_q <= pass_q + 4'd1;
            end else begin
                phase_q <= phase_q + PhaseW'(1);
            end
            if (elem_cycle && (elem_cnt_q != '1)) elem_cnt_q <= elem_cnt_q + 16'd1;
            if (timeout && !vrf_done_i) err_q <= 1'b1;
        end
    end

    // Element result, forced to zero outside element cycles
    always_comb begin
        opa    = use_scalar_q ? scalar_q : vrf_rdata_a_i;
        opb    = vrf_rdata_b_i;
        result = '0;
        case (op_q)
            OP_ADD:  result = opa + opb;
            OP_SUB:  result = opa - opb;
            OP_AND:  result = opa & opb;
            OP_OR:   result = opa | opb;
            OP_XOR:  result = opa ^ opb;
            OP_MIN:  result = ($signed(opa) < $signed(opb)) ? opa : opb;
            OP_MAX:  result = ($signed(opa) > $signed(opb)) ? opa : opb;
            OP_SLL:  result = opa << opb[ShW-1:0];
`ifdef VEC_SEQ_MACC_EN
            OP_MACC: result = opa * opb + vrf_rdata_c_i;
`endif
            default: result = '0;
        endcase
        vrf_wdata_o = elem_cycle ? result : '0;
    end

    assign elem_cnt_o         = elem_cnt_q;
    assign vrf_raddr_a_o      = vs1_q;
    assign vrf_raddr_b_o      = vs2_q;
    assign vrf_waddr_o        = vd_q;
    assign vrf_num_operands_o = num_ops_q;
    assign vrf_lmul_o         = lmul_q;

endmodule

// File: tb/tb_vec_elem_sequencer.sv
// Testbench for vec_elem_sequencer (VLEN=128, ELEN=32, COUNT=4).
// A second instance with TimeoutCycles=16 and vrf_done tied low covers the timeout path.
module tb_vec_elem_sequencer;
    import vec_elem_sequencer_pkg::*;

    localparam int COUNT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    always #5 clk = ~clk;

    logic        instr_valid = 1'b0;
    logic [3:0]  op = '0;
    logic [4:0]  vs1 = '0, vs2 = '0, vd = '0;
    logic [31:0] scalar = '0;
    logic        use_scalar = 1'b0;
    logic [1:0]  nops = '0;
    logic        wb_en = 1'b0;
    vlmul_e      lmul = LMUL_1;
    logic [31:0] rda = '0, rdb = '0, rdc = '0;
    logic        vrf_done = 1'b0;
    logic        vrf_done_to = 1'b0;

    logic        ready, busy, dv, de, req, we;
    logic [15:0] ecnt;
    logic [4:0]  ra_a, ra_b, wa;
    logic [1:0]  nops_o;
    vlmul_e      lmul_o;
    logic [31:0] wdata;

    logic        t_ready, t_busy, t_dv, t_de, t_req, t_we;
    logic [15:0] t_ecnt;
    logic [4:0]  t_ra_a, t_ra_b, t_wa;
    logic [1:0]  t_nops;
    vlmul_e      t_lmul;
    logic [31:0] t_wdata;

    vec_elem_sequencer #(.VLEN(128), .ELEN(32), .AddrWidth(5), .TimeoutCycles(1024)) dut (
        .clk_i(clk), .rst_i(rst), .instr_valid_i(instr_valid), .instr_ready_o(ready),
        .op_i(op), .vs1_i(vs1), .vs2_i(vs2), .vd_i(vd), .scalar_i(scalar),
        .use_scalar_i(use_scalar), .num_operands_i(nops), .wb_en_i(wb_en), .lmul_i(lmul),
        .busy_o(busy), .done_valid_o(dv), .done_error_o(de), .elem_cnt_o(ecnt),
        .vrf_req_o(req), .vrf_we_o(we), .vrf_raddr_a_o(ra_a), .vrf_raddr_b_o(ra_b),
        .vrf_waddr_o(wa), .vrf_num_operands_o(nops_o), .vrf_lmul_o(lmul_o),
        .vrf_rdata_a_i(rda), .vrf_rdata_b_i(rdb), .vrf_rdata_c_i(rdc),
        .vrf_wdata_o(wdata), .vrf_done_i(vrf_done)
    );

    vec_elem_sequencer #(.VLEN(128), .ELEN(32), .AddrWidth(5), .TimeoutCycles(16)) dut_to (
        .clk_i(clk), .rst_i(rst), .instr_valid_i(instr_valid), .instr_ready_o(t_ready),
        .op_i(op), .vs1_i(vs1), .vs2_i(vs2), .vd_i(vd), .scalar_i(scalar),
        .use_scalar_i(use_scalar), .num_operands_i(nops), .wb_en_i(wb_en), .lmul_i(lmul),
        .busy_o(t_busy), .done_valid_o(t_dv), .done_error_o(t_de), .elem_cnt_o(t_ecnt),
        .vrf_req_o(t_req), .vrf_we_o(t_we), .vrf_raddr_a_o(t_ra_a), .vrf_raddr_b_o(t_ra_b),
        .vrf_waddr_o(t_wa), .vrf_num_operands_o(t_nops), .vrf_lmul_o(t_lmul),
        .vrf_rdata_a_i(rda), .vrf_rdata_b_i(rdb), .vrf_rdata_c_i(rdc),
        .vrf_wdata_o(t_wdata), .vrf_done_i(vrf_done_to)
    );

    int checks = 0;
    int failures = 0;

    logic [31:0] va [64];
    logic [31:0] vb [64];
    logic [31:0] vc [64];
    logic [31:0] ea [64];

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;
    vec_t tv [12];

    vlmul_e lms [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_op(input logic [3:0] o, input logic [31:0] a,
                                           input logic [31:0] b, input logic [31:0] c);
        case (o)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return a & b;
            4'd3: return a | b;
            4'd4: return a ^ b;
            4'd5: return ($signed(a) < $signed(b)) ? a : b;
            4'd6: return ($signed(a) > $signed(b)) ? a : b;
            4'd7: return a << b[4:0];
            4'd8: return a * b + c;
            default: return 32'h0;
        endcase
    endfunction

    // Elements streamed per register pass and number of passes for a grouping
    task automatic sched(input vlmul_e lm, output int cnt, output int passes);
        int code;
        code = int'(lm);
        if (code >= 5) begin
            cnt    = COUNT >> (8 - code);
            passes = 1;
        end else begin
            cnt    = COUNT;
            passes = 1 << code;
        end
    endtask

    task automatic fill_random(input logic [3:0] o, input logic us, input logic [31:0] sc, input int n);
        for (int i = 0; i < n; i++) begin
            va[i] = $urandom;
            vb[i] = ($urandom_range(0, 3) == 0) ? va[i] : $urandom;
            vc[i] = $urandom;
            ea[i] = ref_op(o, us ? sc : va[i], vb[i], vc[i]);
        end
    endtask

    task automatic scramble_fields();
        op     = 4'($urandom);
        vs1    = 5'($urandom);
        vs2    = 5'($urandom);
        vd     = 5'($urandom);
        scalar = $urandom;
        nops   = 2'($urandom);
        wb_en  = 1'($urandom);
        use_scalar = 1'($urandom);
    endtask

    task automatic run_instr(input logic [3:0] o, input vlmul_e lm, input logic [1:0] n,
                             input logic us, input logic [31:0] sc, input logic wb, input bit garbage);
        int cnt, passes, plen, total, ei, ph;
        bit is_el;
        logic [4:0] s1, s2, d;
        sched(lm, cnt, passes);
        plen  = int'(n) + cnt + 2;
        total = plen * passes;
        s1 = 5'($urandom);
        s2 = 5'($urandom);
        d  = 5'($urandom);
        // stray vrf_done while idle must be ignored
        @(negedge clk);
        vrf_done = 1'b1;
        @(negedge clk);
        vrf_done = 1'b0;
        #1;
        chk("idle_done_ignored_busy", busy, 1'b0);
        chk("idle_done_ignored_dv", dv, 1'b0);
        op = o; lmul = lm; nops = n; use_scalar = us; scalar = sc; wb_en = wb;
        vs1 = s1; vs2 = s2; vd = d;
        instr_valid = 1'b1;
        chk("accept_ready", ready, 1'b1);
        @(negedge clk);
        instr_valid = garbage;
        if (garbage) scramble_fields();
        ei = 0;
        for (int t = 0; t < total; t++) begin
            ph    = t % plen;
            is_el = (ph > int'(n)) && (ph <= int'(n) + cnt);
            rda = is_el ? va[ei] : $urandom;
            rdb = is_el ? vb[ei] : $urandom;
            rdc = is_el ? vc[ei] : $urandom;
            vrf_done = (t == total - 1);
            #1;
            chk("run_req", req, 1'b1);
            chk("run_we", we, wb);
            chk("run_raddr_a", ra_a, s1);
            chk("run_raddr_b", ra_b, s2);
            chk("run_waddr", wa, d);
            chk("run_nops", nops_o, n);
            chk("run_lmul", lmul_o, lm);
            chk("run_ready", ready, 1'b0);
            chk("run_dv", dv, 1'b0);
            chk("wdata", wdata, is_el ? ea[ei] : 32'h0);
            if (is_el) ei++;
            @(negedge clk);
            if (garbage) scramble_fields();
        end
        instr_valid = 1'b0;
        vrf_done = 1'b0;
        #1;
        chk("done_valid", dv, 1'b1);
        chk("done_error", de, 1'b0);
        chk("done_req_low", req, 1'b0);
        chk("done_elem_cnt", ecnt, 32'(cnt * passes));
        @(negedge clk);
        #1;
        chk("post_ready", ready, 1'b1);
        chk("post_dv", dv, 1'b0);
        chk("post_elem_cnt_hold", ecnt, 32'(cnt * passes));
    endtask

    task automatic run_illegal(input logic [3:0] o);
        @(negedge clk);
        op = o; lmul = LMUL_1; nops = 2'd2; wb_en = 1'b1; use_scalar = 1'b0;
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        #1;
        chk("illegal_dv", dv, 1'b1);
        chk("illegal_err", de, 1'b1);
        chk("illegal_req", req, 1'b0);
        chk("illegal_elem_cnt", ecnt, 32'h0);
        @(negedge clk);
        #1;
        chk("illegal_ready_back", ready, 1'b1);
        chk("illegal_dv_once", dv, 1'b0);
        chk("illegal_req_still", req, 1'b0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cnt, passes;
        logic [3:0] o;
        vlmul_e lm;
        logic [1:0] n;
        logic us, wb;
        logic [31:0] sc;

        tv[0]  = '{4'd0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000};
        tv[1]  = '{4'd1, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF};
        tv[2]  = '{4'd2, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000};
        tv[3]  = '{4'd3, 32'h0000_F0F0, 32'h0000_0F0F, 32'h0000_FFFF};
        tv[4]  = '{4'd4, 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555};
        tv[5]  = '{4'd5, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF};
        tv[6]  = '{4'd6, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001};
        tv[7]  = '{4'd5, 32'h8000_0000, 32'h7FFF_FFFF, 32'h8000_0000};
        tv[8]  = '{4'd6, 32'h8000_0000, 32'h7FFF_FFFF, 32'h7FFF_FFFF};
        tv[9]  = '{4'd7, 32'h0000_0001, 32'h0000_0023, 32'h0000_0008};
        tv[10] = '{4'd7, 32'h8000_0001, 32'h0000_0021, 32'h0000_0002};
        tv[11] = '{4'd7, 32'h1234_5678, 32'h0000_0020, 32'h1234_5678};
        lms = '{LMUL_F8, LMUL_F4, LMUL_F2, LMUL_1, LMUL_2, LMUL_4, LMUL_8};

        // reset state
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_ready", ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_dv", dv, 1'b0);
        chk("rst_de", de, 1'b0);
        chk("rst_req", req, 1'b0);
        chk("rst_we", we, 1'b0);
        chk("rst_elem_cnt", ecnt, 32'h0);
        chk("rst_waddr", wa, 32'h0);
        chk("rst_raddr_a", ra_a, 32'h0);
        chk("rst_wdata", wdata, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // ADD M1 with known streams
        va[0:3] = '{32'd1, 32'd2, 32'd3, 32'd4};
        vb[0:3] = '{32'd10, 32'd20, 32'd30, 32'd40};
        vc[0:3] = '{32'd0, 32'd0, 32'd0, 32'd0};
        ea[0:3] = '{32'd11, 32'd22, 32'd33, 32'd44};
        run_instr(4'd0, LMUL_1, 2'd2, 1'b0, 32'h0, 1'b1, 1'b0);

        // table of ALU corner vectors
        for (int k = 0; k < 12; k++) begin
            for (int i = 0; i < COUNT; i++) begin
                va[i] = tv[k].a;
                vb[i] = tv[k].b;
                vc[i] = $urandom;
                ea[i] = tv[k].exp;
            end
            run_instr(tv[k].op, LMUL_1, 2'd2, 1'b0, 32'h0, 1'b1, 1'b0);
        end

        // XOR M2: two passes, 16 request cycles, 8 elements
        fill_random(4'd4, 1'b0, 32'h0, 8);
        run_instr(4'd4, LMUL_2, 2'd2, 1'b0, 32'h0, 1'b1, 1'b0);

        // SUB .vx F2
        va[0:1] = '{32'd7, 32'd3};
        vb[0:1] = '{32'd3, 32'd7};
        vc[0:1] = '{32'd0, 32'd0};
        ea[0:1] = '{32'd2, 32'hFFFF_FFFE};
        run_instr(4'd1, LMUL_F2, 2'd1, 1'b1, 32'd5, 1'b0, 1'b0);

        // illegal opcodes
        run_illegal(4'hF);
        run_illegal(4'd9);

        // MACC
`ifdef VEC_SEQ_MACC_EN
        for (int i = 0; i < COUNT; i++) begin
            va[i] = 32'd3; vb[i] = 32'd4; vc[i] = 32'd5; ea[i] = 32'd17;
        end
        run_instr(4'd8, LMUL_1, 2'd3, 1'b0, 32'h0, 1'b1, 1'b0);
`else
        run_illegal(4'd8);
`endif

        // randomized instructions against the reference model
        for (int r = 0; r < 30; r++) begin
`ifdef VEC_SEQ_MACC_EN
            o = 4'($urandom_range(0, 8));
`else
            o = 4'($urandom_range(0, 7));
`endif
            lm = lms[$urandom_range(0, 6)];
            n  = 2'($urandom_range(0, 3));
            us = 1'($urandom);
            wb = 1'($urandom);
            sc = $urandom;
            sched(lm, cnt, passes);
            fill_random(o, us, sc, cnt * passes);
            run_instr(o, lm, n, us, sc, wb, bit'($urandom_range(0, 1)));
        end

        // timeout on the 16-cycle instance
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        op = 4'd0; lmul = LMUL_8; nops = 2'd3; wb_en = 1'b1;
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        for (int t = 0; t < 16; t++) begin
            #1;
            chk("to_req_high", t_req, 1'b1);
            chk("to_no_done_yet", t_dv, 1'b0);
            @(negedge clk);
        end
        #1;
        chk("to_done_valid", t_dv, 1'b1);
        chk("to_done_error", t_de, 1'b1);
        chk("to_req_dropped", t_req, 1'b0);
        @(negedge clk);
        #1;
        chk("to_ready_back", t_ready, 1'b1);
        chk("to_dv_once", t_dv, 1'b0);

        // reset in the middle of a run
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        op = 4'd2; lmul = LMUL_4; nops = 2'd1;
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("midrst_running", t_req, 1'b1);
        chk("midrst_running_main", req, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_t_ready", t_ready, 1'b1);
        chk("midrst_t_req", t_req, 1'b0);
        chk("midrst_t_busy", t_busy, 1'b0);
        chk("midrst_ready", ready, 1'b1);
        chk("midrst_req", req, 1'b0);
        chk("midrst_elem_cnt", ecnt, 32'h0);
        for (int i = 0; i < 4; i++) begin
            chk("midrst_no_done", dv, 1'b0);
            chk("midrst_no_done_to", t_dv, 1'b0);
            @(negedge clk);
            #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
